// File: rtl/ifmap_window_gen_if.sv
// ifmap_window_gen_if
//   Bundles the pixel stream going into the window generator and the window
//   stream coming out of it.
//   master : pixel producer / window consumer (drives pix_*, observes window)
//   slave  : the window generator (observes pix_*, drives window outputs)
//   Signals:
//     pix_valid    pixel present this cycle
//     pix_in       8-bit activation, raster order
//     ifmap        72-bit 3x3 window, tap k = 3*r + c at [8*k +: 8]
//     ifmap_valid  one-cycle strobe, ifmap carries a new window
//     frame_done   one-cycle strobe after the last pixel of a frame
interface ifmap_window_gen_if;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic [71:0] ifmap;
    logic        ifmap_valid;
    logic        frame_done;

    modport master (
        output pix_valid,
        output pix_in,
        input  ifmap,
        input  ifmap_valid,
        input  frame_done
    );

    modport slave (
        input  pix_valid,
        input  pix_in,
        output ifmap,
        output ifmap_valid,
        output frame_done
    );
endinterface

// File: rtl/ifmap_window_gen.sv
// ifmap_window_gen
//   Turns a raster-order stream of 8-bit activations into 3x3 windows for
//   every valid (unpadded, stride-1) convolution position. Two line buffers
//   hold the previous two rows; nine window registers shift left one column
//   per accepted pixel.
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset
//     s     slave side of ifmap_window_gen_if (pixel in, window out)
//   Parameters:
//     IMG_W, IMG_H  image size in pixels, 3..256 each
module ifmap_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ifmap_window_gen_if.slave    s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [0:0] {FILL, STREAM} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [71:0]     r_ifmap;
    logic            r_ifmap_valid;
    logic            r_frame_done;

    logic            w_accept;
    logic            w_last_col;
    logic            w_last_row;
    logic [CW-1:0]   w_col_next;

    assign w_accept   = s.pix_valid;
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));

    // Column the next accept will use. The line buffers are read one cycle
    // ahead at this address so the read can be registered.
    always_comb begin
        w_col_next = r_col;
        if (rst) begin
            w_col_next = '0;
        end else if (w_accept) begin
            w_col_next = w_last_col ? '0 : r_col + CW'(1);
        end
    end

    // Line buffers: LB0 holds row-1, LB1 holds row-2, indexed by column.
    // The registered read is prefetched at w_col_next. An accept writes only
    // address r_col and then moves r_col, so the prefetched word is never
    // stale (IMG_W >= 3 keeps read and write addresses distinct).
    logic [7:0] r_lb0_mem [IMG_W];
    logic [7:0] r_lb1_mem [IMG_W];
    logic [7:0] r_lb0_rd;
    logic [7:0] r_lb1_rd;

    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_lb1_mem[r_col] <= r_lb0_rd;
            r_lb0_mem[r_col] <= s.pix_in;
        end
        r_lb0_rd <= r_lb0_mem[w_col_next];
        r_lb1_rd <= r_lb1_mem[w_col_next];
    end

    // Window registers, tap k = 3*r + c. Columns 0/1 take the column to
    // their right; column 2 takes the new column {LB1, LB0, pix_in}.
    logic [7:0]  r_win      [9];
    logic [7:0]  w_win_next [9];
    logic [7:0]  w_new_col  [3];
    logic [71:0] w_win_flat;

    assign w_new_col[0] = r_lb1_rd;
    assign w_new_col[1] = r_lb0_rd;
    assign w_new_col[2] = s.pix_in;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_tap
            if ((gi % 3) < 2) begin : g_shift
                assign w_win_next[gi] = r_win[gi + 1];
            end else begin : g_load
                assign w_win_next[gi] = w_new_col[gi / 3];
            end

            assign w_win_flat[8*gi +: 8] = w_win_next[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_win[gi] <= '0;
                end else if (w_accept) begin
                    r_win[gi] <= w_win_next[gi];
                end
            end
        end
    endgenerate

    // Position counters, FILL/STREAM control and registered outputs.
    // Columns 0/1 in STREAM still carry previous-row data in the window
    // registers, so only col >= 2 publishes a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_col         <= '0;
            r_row         <= '0;
            r_ifmap       <= '0;
            r_ifmap_valid <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_ifmap_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            if (w_accept) begin
                r_col <= w_col_next;
                if (w_last_col) begin
                    r_row <= w_last_row ? '0 : r_row + RW'(1);
                end
                case (r_state)
                    FILL: begin
                        if (w_last_col && r_row == RW'(1)) begin
                            r_state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (r_col >= CW'(2)) begin
                            r_ifmap       <= w_win_flat;
                            r_ifmap_valid <= 1'b1;
                        end
                        if (w_last_col && w_last_row) begin
                            r_frame_done <= 1'b1;
                            r_state      <= FILL;
                        end
                    end
                    default: r_state <= FILL;
                endcase
            end
        end
    end

    assign s.ifmap       = r_ifmap;
    assign s.ifmap_valid = r_ifmap_valid;
    assign s.frame_done  = r_frame_done;
endmodule

// File: tb/tb_ifmap_window_gen.sv
// tb_ifmap_window_gen
//   Directed bench for ifmap_window_gen: a 4x4 instance (continuous stream,
//   gapped stream, mid-frame reset, back-to-back frames) and a 5x3 instance
//   (row-wrap gating). Expected windows are hand-written tables.
module tb_ifmap_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ifmap_window_gen_if ifa ();
    ifmap_window_gen_if ifb ();

    ifmap_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .s   (ifa)
    );

    ifmap_window_gen #(.IMG_W(5), .IMG_H(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .s   (ifb)
    );

    int n_vec = 0;
    int n_err = 0;
    int win_cnt_a = 0;
    int fd_cnt_a = 0;
    logic [71:0] exp_a_ifmap = '0;
    logic [71:0] exp_b_ifmap = '0;

    int tab_a [4][9] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},
                         '{2, 3, 4, 6, 7, 8, 10, 11, 12},
                         '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                         '{6, 7, 8, 10, 11, 12, 14, 15, 16}};

    int tab_b [3][9] = '{'{1, 2, 3, 6, 7, 8, 11, 12, 13},
                         '{2, 3, 4, 7, 8, 9, 12, 13, 14},
                         '{3, 4, 5, 8, 9, 10, 13, 14, 15}};

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win_a(input int j, input int base);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(tab_a[j][k] + base);
        return w;
    endfunction

    function automatic logic [71:0] win_b(input int j);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(tab_b[j][k]);
        return w;
    endfunction

    // One cycle on instance A; outputs are checked #1 after the edge.
    task automatic step_a(input logic v, input logic [7:0] d, input logic exp_v,
                          input logic exp_fd, input logic [71:0] exp_win);
        ifa.pix_valid = v;
        ifa.pix_in    = d;
        @(posedge clk);
        #1;
        ifa.pix_valid = 1'b0;
        if (exp_v) exp_a_ifmap = exp_win;
        chk("A.valid", 72'(ifa.ifmap_valid), 72'(exp_v));
        chk("A.frame_done", 72'(ifa.frame_done), 72'(exp_fd));
        chk("A.ifmap", ifa.ifmap, exp_a_ifmap);
        if (ifa.ifmap_valid) begin
            win_cnt_a++;
            $display("A window ifmap=%h fd=%b", ifa.ifmap, ifa.frame_done);
        end
        if (ifa.frame_done) fd_cnt_a++;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d, input logic exp_v,
                          input logic exp_fd, input logic [71:0] exp_win);
        ifb.pix_valid = v;
        ifb.pix_in    = d;
        @(posedge clk);
        #1;
        ifb.pix_valid = 1'b0;
        if (exp_v) exp_b_ifmap = exp_win;
        chk("B.valid", 72'(ifb.ifmap_valid), 72'(exp_v));
        chk("B.frame_done", 72'(ifb.frame_done), 72'(exp_fd));
        chk("B.ifmap", ifb.ifmap, exp_b_ifmap);
        if (ifb.ifmap_valid)
            $display("B window ifmap=%h fd=%b", ifb.ifmap, ifb.frame_done);
    endtask

    // Full 4x4 frame of base+1..base+16, optionally with 0-3 idle cycles
    // before each pixel.
    task automatic run_frame_a(input int base, input bit gaps);
        for (int p = 0; p < 16; p++) begin
            int g;
            int wi;
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int i = 0; i < g; i++) step_a(1'b0, 8'h00, 1'b0, 1'b0, '0);
            case (p)
                10:      wi = 0;
                11:      wi = 1;
                14:      wi = 2;
                15:      wi = 3;
                default: wi = -1;
            endcase
            step_a(1'b1, 8'(base + p + 1), wi >= 0, p == 15,
                   (wi >= 0) ? win_a(wi, base) : 72'd0);
        end
    endtask

    initial begin
        ifa.pix_valid = 1'b0;
        ifa.pix_in    = '0;
        ifb.pix_valid = 1'b0;
        ifb.pix_in    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("A.rst_ifmap", ifa.ifmap, '0);
        chk("A.rst_valid", 72'(ifa.ifmap_valid), '0);
        chk("A.rst_fd", 72'(ifa.frame_done), '0);
        chk("B.rst_ifmap", ifb.ifmap, '0);
        chk("B.rst_valid", 72'(ifb.ifmap_valid), '0);
        chk("B.rst_fd", 72'(ifb.frame_done), '0);
        rst = 1'b0;

        // 5x3 row wrap: windows only after pixels 13, 14, 15
        for (int p = 0; p < 15; p++) begin
            int wi;
            wi = (p >= 12) ? p - 12 : -1;
            step_b(1'b1, 8'(p + 1), wi >= 0, p == 14, (wi >= 0) ? win_b(wi) : 72'd0);
        end
        for (int i = 0; i < 2; i++) step_b(1'b0, 8'h00, 1'b0, 1'b0, '0);

        // 4x4 continuous frame
        run_frame_a(0, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, '0);

        // 4x4 frame with random gaps
        run_frame_a(0, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b0, 8'h00, 1'b0, 1'b0, '0);

        // Mid-frame reset: 6 junk pixels, reset with a pixel offered, full frame
        for (int p = 0; p < 6; p++) step_a(1'b1, 8'(200 + p), 1'b0, 1'b0, '0);
        rst = 1'b1;
        ifa.pix_valid = 1'b1;
        ifa.pix_in    = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.pix_valid = 1'b0;
        exp_a_ifmap = '0;
        chk("A.mrst_ifmap", ifa.ifmap, '0);
        chk("A.mrst_valid", 72'(ifa.ifmap_valid), '0);
        chk("A.mrst_fd", 72'(ifa.frame_done), '0);
        run_frame_a(0, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, '0);

        // Back-to-back frames
        win_cnt_a = 0;
        fd_cnt_a  = 0;
        run_frame_a(0, 1'b0);
        run_frame_a(100, 1'b0);
        for (int i = 0; i < 2; i++) step_a(1'b0, 8'h00, 1'b0, 1'b0, '0);
        chk("A.b2b_windows", 72'(win_cnt_a), 72'd8);
        chk("A.b2b_frame_done", 72'(fd_cnt_a), 72'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
